seg7_dev: RTL and testbench
===========================

Name: seg7_dev

Overview:
Scanned 7-segment display driver for a 4-anode, 8-segment common-anode display.
- Takes a 3-bit scan index from an external scan counter and a 32-bit display word.
- Produces the active-low anode select and active-low segment pattern for the currently scanned digit.
- Text mode (SW0=1): hex-digit decoding with per-digit decimal point and flash blanking.
- Graphic mode (SW0=0): raw segment bytes are passed straight through.
- Sits between the board-level display data mux and the FPGA 7-segment pins.

Parameters:
none

Ports:
clk      input   1   system clock; all outputs registered on rising edge
rst      input   1   synchronous active-high reset
flash    input   1   blink phase; 1 = blank digits whose LES bit is set (text mode)
Scan     input   3   digit scan index, 0..7
Hexs     input   32  display data: 8 hex nibbles (text mode) or 4 raw segment bytes (graphic mode)
point    input   8   per-digit decimal point enable, 1 = dp lit (text mode)
LES      input   8   per-digit blink enable, 1 = digit blanks while flash=1 (text mode)
SW0      input   1   mode select: 1 = text/hex, 0 = graphic/raw
AN       output  4   anode select, active-low, one-hot-zero
SEGMENT  output  8   segments, active-low; bit7=dp, bit6..0 = g,f,e,d,c,b,a

Behaviour:
- Reset (rst=1 at rising clk): AN=4'b1111, SEGMENT=8'hFF (display dark). Reset has priority over all inputs.
- Latency: 1 clock. Outputs are registered from combinational next-values computed from the current inputs; no other state.
- Anode: AN_next = ~(4'b0001 << Scan[1:0]) in both modes. Scan[2] never affects AN.
- Text mode (SW0=1):
  - Index k = Scan[2:0]; nibble = Hexs[4k+3:4k].
  - blank = LES[k] & flash.
  - If blank: SEGMENT_next = 8'hFF.
  - Else: SEGMENT_next = {~point[k], hex7(nibble)}.
- hex7 (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Graphic mode (SW0=0):
  - j = Scan[1:0]; SEGMENT_next = Hexs[8j+7:8j], passed through unmodified.
  - point, LES and flash are ignored; Scan[2] is ignored.
- Mode change, Scan change or data change take effect on the next rising edge. No glitch filtering; no internal scan counter.
- Any X-free input combination is legal. All 8 Scan values are valid in both modes.

Test Plan:
- Reset: rst=1 for 1 cycle with arbitrary inputs -> AN=4'hF, SEGMENT=8'hFF. After rst deasserts, outputs follow inputs with 1-cycle latency.
- Text sweep: SW0=1, Hexs=32'h12345678, point=0, LES=8'hFF, flash=0; Scan steps 0..7, one per cycle.
  - Expected SEGMENT: 80, F8, 82, 92, 99, B0, A4, F9.
  - Expected AN: E, D, B, 7, E, D, B, 7.
- Decimal point: SW0=1, Hexs=32'h12345678, point=8'h08, Scan=3, flash=0 -> SEGMENT=8'h12, AN=4'b0111.
- Flash blanking: SW0=1, LES=8'hFF, flash=1, any Scan -> SEGMENT=8'hFF, AN unchanged. With LES=8'h00, flash=1, Scan=0 -> SEGMENT=8'h80 (Hexs=12345678).
- Graphic sweep: SW0=0, Hexs=32'h557EF7E0, point=8'hFF, flash=1; Scan steps 0..7.
  - Expected SEGMENT: E0, F7, 7E, 55, E0, F7, 7E, 55.
  - Expected AN: E, D, B, 7, E, D, B, 7.
- Hex decode coverage: SW0=1, Hexs=32'h89ABCDEF and then 32'h01234567, all Scan values, point=0, flash=0 -> each SEGMENT[6:0] matches the hex7 table, SEGMENT[7]=1.

Source files
------------

// File: rtl/seg7_dev.sv
// Scanned 7-segment driver for a 4-anode common-anode display.
// Text mode decodes hex nibbles with dp/blink; graphic mode passes raw segment bytes.
module seg7_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic        flash,
    input  logic [2:0]  Scan,
    input  logic [31:0] Hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  LES,
    input  logic        SW0,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT
);

    logic [3:0] an_d, an_q;
    logic [7:0] seg_d, seg_q;
    logic [3:0] nibble;
    logic [7:0] raw_byte;
    logic       blank;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        an_d     = ~(4'b0001 << Scan[1:0]);
        nibble   = Hexs[{Scan, 2'b00} +: 4];
        raw_byte = Hexs[{Scan[1:0], 3'b000} +: 8];
        blank    = LES[Scan] & flash;
        seg_d    = 8'hFF;
        if (SW0) begin
            if (!blank)
                seg_d = {~point[Scan], hex7(nibble)};
        end else begin
            seg_d = raw_byte;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over all inputs.
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg7_dev.sv
// Directed self-checking bench for seg7_dev with hand-computed expected values.
module tb_seg7_dev;

    logic        clk = 1'b0;
    logic        rst;
    logic        flash;
    logic [2:0]  Scan;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        SW0;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    int compared   = 0;
    int mismatched = 0;

    seg7_dev dut (
        .clk     (clk),
        .rst     (rst),
        .flash   (flash),
        .Scan    (Scan),
        .Hexs    (Hexs),
        .point   (point),
        .LES     (LES),
        .SW0     (SW0),
        .AN      (AN),
        .SEGMENT (SEGMENT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Clock once with the current inputs, then sample 1 ns after the edge.
    task automatic tick_and_check(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        @(posedge clk);
        #1;
        check({tag, " AN"}, {4'h0, AN}, {4'h0, exp_an});
        check({tag, " SEG"}, SEGMENT, exp_seg);
    endtask

    logic [7:0] text_seg  [8];
    logic [7:0] graph_seg [8];
    logic [7:0] hexa_seg  [8];
    logic [7:0] hexb_seg  [8];
    logic [3:0] an_exp    [8];

    initial begin
        text_seg  = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        graph_seg = '{8'hE0, 8'hF7, 8'h7E, 8'h55, 8'hE0, 8'hF7, 8'h7E, 8'h55};
        hexa_seg  = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        hexb_seg  = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        an_exp    = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

        // Reset with live, non-dark inputs: reset must win.
        rst = 1'b1; SW0 = 1'b1; Hexs = 32'h12345678; point = 8'hFF;
        LES = 8'h00; flash = 1'b0; Scan = 3'd1;
        @(negedge clk);
        tick_and_check("reset", 4'hF, 8'hFF);

        // First cycle after reset follows inputs: digit 1 = '7' with dp lit.
        rst = 1'b0;
        tick_and_check("post_reset", 4'hD, 8'h78);

        // Text sweep.
        point = 8'h00; LES = 8'hFF; flash = 1'b0;
        for (int k = 0; k < 8; k++) begin
            Scan = 3'(k);
            tick_and_check($sformatf("text_sweep%0d", k), an_exp[k], text_seg[k]);
        end

        // Decimal point on digit 3.
        point = 8'h08; Scan = 3'd3;
        tick_and_check("dp_digit3", 4'h7, 8'h12);
        // Decimal point on digit 3 must not leak to digit 7.
        Scan = 3'd7;
        tick_and_check("dp_digit7", 4'h7, 8'hF9);

        // Flash blanking with all digits enabled for blink.
        point = 8'h00; LES = 8'hFF; flash = 1'b1;
        Scan = 3'd0;
        tick_and_check("blank_s0", 4'hE, 8'hFF);
        Scan = 3'd6;
        tick_and_check("blank_s6", 4'hB, 8'hFF);
        LES = 8'h00; Scan = 3'd0;
        tick_and_check("noblank_s0", 4'hE, 8'h80);
        // Per-digit blink: only digit 2 blanks.
        LES = 8'h04; Scan = 3'd2;
        tick_and_check("les_bit2_s2", 4'hB, 8'hFF);
        Scan = 3'd3;
        tick_and_check("les_bit2_s3", 4'h7, 8'h92);
        Scan = 3'd6;
        tick_and_check("les_bit2_s6", 4'hB, 8'hA4);

        // Graphic sweep: dp/blink inputs must be ignored.
        SW0 = 1'b0; Hexs = 32'h557EF7E0; point = 8'hFF; LES = 8'hFF; flash = 1'b1;
        for (int k = 0; k < 8; k++) begin
            Scan = 3'(k);
            tick_and_check($sformatf("graph_sweep%0d", k), an_exp[k], graph_seg[k]);
        end

        // Hex decode coverage.
        SW0 = 1'b1; point = 8'h00; flash = 1'b0; LES = 8'h00;
        Hexs = 32'h89ABCDEF;
        for (int k = 0; k < 8; k++) begin
            Scan = 3'(k);
            tick_and_check($sformatf("hexA%0d", k), an_exp[k], hexa_seg[k]);
        end
        Hexs = 32'h01234567;
        for (int k = 0; k < 8; k++) begin
            Scan = 3'(k);
            tick_and_check($sformatf("hexB%0d", k), an_exp[k], hexb_seg[k]);
        end

        // Reset mid-run darkens the display again.
        rst = 1'b1;
        tick_and_check("reset_again", 4'hF, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
